exec_trace_capture: RTL

EXEC_TRACE_CAPTURE -- requirements
Module: exec_trace_capture

---
 rtl/exec_trace_pkg.sv | 22 ++
 rtl/trace_fifo.sv | 52 +++++
 rtl/exec_trace_capture.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/exec_trace_pkg.sv
// exec_trace_pkg: shared capture-FSM state encoding and default parameter values
// for the execution trace capture block.
// No ports; imported by exec_trace_capture.
package exec_trace_pkg;

  // Encoding is visible on the `state` port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 24;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NREG    = 32;
  localparam int DEF_DELAY   = 1;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_SEQ_W   = 16;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO holding trace records, DEPTH (power of 2, >= 2) x W.
// Ports: push_vld/push_dat/push_rdy write side; pop_vld/pop_rdy/pop_dat read side
// (valid/ready); full/empty flags. pop_dat reads 0 while empty.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop_rdy && !empty;
  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign push_rdy = !full || do_pop;
  assign do_push  = push_vld && push_rdy;
  assign pop_vld  = !empty;
  assign pop_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/exec_trace_capture.sv
// exec_trace_capture: arms on `arm`, triggers on a (optionally address-matched)
// delayed fetch, then records {addr, instr, writeback, seq} into a trace FIFO.
// Ports: clk/rst; arm/stop control; trig_en/trig_addr; in_* fetch; wb_* writeback;
// out_* record stream (valid/ready); overflow/drop_cnt/state status; rd_idx/rd_data.
// Optional macro TRACE_SHADOW_REGS_EN adds a shadow register file read via rd_idx.
module exec_trace_capture
  import exec_trace_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NREG    = DEF_NREG,
  parameter int IDX_W   = $clog2(NREG),
  parameter int DELAY   = DEF_DELAY,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int SEQ_W   = DEF_SEQ_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               stop,
  input  logic               trig_en,
  input  logic [ADDR_W-1:0]  trig_addr,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               wb_en,
  input  logic [IDX_W-1:0]   wb_idx,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_wb_en,
  output logic [IDX_W-1:0]   out_wb_idx,
  output logic [DATA_W-1:0]  out_wb_data,
  output logic [SEQ_W-1:0]   out_seq,
  output logic               overflow,
  output logic [7:0]         drop_cnt,
  output logic [1:0]         state,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [DATA_W-1:0]  rd_data
);

  localparam int REC_W = ADDR_W + INSTR_W + 1 + IDX_W + DATA_W + SEQ_W;

  logic               d_valid;
  logic [ADDR_W-1:0]  d_addr;
  logic [INSTR_W-1:0] d_instr;

  // Fetch-side delay line so the fetched instruction lines up with its writeback.
  if (DELAY == 0) begin : g_nodly
    assign d_valid = in_valid;
    assign d_addr  = in_addr;
    assign d_instr = in_instr;
  end else begin : g_dly
    logic [DELAY-1:0]   v_q;
    logic [ADDR_W-1:0]  a_q [DELAY];
    logic [INSTR_W-1:0] i_q [DELAY];
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
        for (int k = 0; k < DELAY; k++) begin
          a_q[k] <= '0;
          i_q[k] <= '0;
        end
      end else begin
        v_q[0] <= in_valid;
        a_q[0] <= in_addr;
        i_q[0] <= in_instr;
        for (int k = 1; k < DELAY; k++) begin
          v_q[k] <= v_q[k-1];
          a_q[k] <= a_q[k-1];
          i_q[k] <= i_q[k-1];
        end
      end
    end
    assign d_valid = v_q[DELAY-1];
    assign d_addr  = a_q[DELAY-1];
    assign d_instr = i_q[DELAY-1];
  end

  trace_state_e state_q, state_d;
  logic [SEQ_W-1:0] seq_q;
  logic             overflow_q;
  logic [7:0]       drop_cnt_q;
  logic             arm_acc, trig, hit, push_vld, seq_inc, drop;
  logic             fifo_full;
  logic             unused_push_rdy, unused_fifo_empty;
  logic [REC_W-1:0] push_dat, pop_dat;

  assign hit = d_valid && (!trig_en || (d_addr == trig_addr));

  always_comb begin
    state_d = state_q;
    arm_acc = 1'b0;
    trig    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d = ST_ARMED;
          arm_acc = 1'b1;
        end
      end
      ST_ARMED: begin
        // stop wins over a trigger landing in the same cycle
        if (stop) begin
          state_d = ST_DONE;
        end else if (hit) begin
          state_d = ST_CAPTURE;
          trig    = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (stop) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The trigger record is captured; a stop cycle records nothing.
  assign push_vld = trig || (state_q == ST_CAPTURE && d_valid && !stop);
  assign seq_inc  = d_valid && (state_q == ST_ARMED || state_q == ST_CAPTURE);
  assign drop     = push_vld && fifo_full && !(out_valid && out_ready);
  assign push_dat = {d_addr, d_instr, wb_en, wb_idx, wb_data, seq_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (arm_acc) begin
        seq_q      <= '0;
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end else begin
        if (seq_inc) seq_q <= seq_q + 1'b1;
        if (drop) begin
          overflow_q <= 1'b1;
          if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end
  end

  trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .push_rdy (unused_push_rdy),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (unused_fifo_empty)
  );

  assign {out_addr, out_instr, out_wb_en, out_wb_idx, out_wb_data, out_seq} = pop_dat;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign state    = state_q;

`ifdef TRACE_SHADOW_REGS_EN
  // Shadow copy of the register file; reads see the value before this cycle's write.
  logic [DATA_W-1:0] shadow_q [NREG];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) shadow_q[r] <= '0;
    end else if (wb_en) begin
      shadow_q[wb_idx] <= wb_data;
    end
  end
  assign rd_data = shadow_q[rd_idx];
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_data       = '0;
`endif

endmodule
